// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle M-extension unit beside the EX-stage ALU (fixed-latency multiply, radix-2 restoring divide).
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| complete directly from IDLE.
module muldiv_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [4:0]      AlUop,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    localparam logic [4:0]      MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0]      DIV_LAST = 5'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, ovf, early, div_short;
    logic [XLEN-1:0] short_res;
    logic [1:0]      mul_op;
    logic [XLEN-1:0] mul_src_a, mul_src_b, mul_res;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] rem_nx, q_fin, div_res;
    logic            neg_q, neg_r;

    // Sign-extending to the full product width keeps the low 2*XLEN bits exact for every signedness mix.
    function automatic logic [XLEN-1:0] mul_word(input logic [1:0]      op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic                a_sx, b_sx;
        logic [2*XLEN-1:0]   a_ext, b_ext, prod;
        a_sx  = (op == 2'b01 || op == 2'b10) & a[XLEN-1];
        b_sx  = (op == 2'b01) & b[XLEN-1];
        a_ext = {{XLEN{a_sx}}, a};
        b_ext = {{XLEN{b_sx}}, b};
        prod  = a_ext * b_ext;
        return (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    // Operand decode for the accept cycle and the shared arithmetic.
    always_comb begin
        a_mag  = (~AlUop[0] & operand_A[XLEN-1]) ? -operand_A : operand_A;
        b_mag  = (~AlUop[0] & operand_B[XLEN-1]) ? -operand_B : operand_B;
        b_zero = (operand_B == '0);
        ovf    = ~AlUop[0] & (operand_A == INT_MIN) & (operand_B == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early  = ~b_zero & (a_mag < b_mag);
`else
        early  = 1'b0;
`endif
        div_short = b_zero | ovf | early;

        if (b_zero) begin
            short_res = AlUop[1] ? operand_A : '1;
        end else if (ovf) begin
            short_res = AlUop[1] ? '0 : INT_MIN;
        end else begin
            short_res = AlUop[1] ? operand_A : '0;
        end

        // MUL_CYCLES==1 finishes from IDLE, so the multiplier then reads the live operands.
        mul_op    = (state_q == IDLE) ? AlUop[1:0] : op_q;
        mul_src_a = (state_q == IDLE) ? operand_A  : a_q;
        mul_src_b = (state_q == IDLE) ? operand_B  : b_q;
        mul_res   = mul_word(mul_op, mul_src_a, mul_src_b);

        shifted = {rem_q, quo_q[XLEN-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        rem_nx  = ge ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
        q_fin   = {quo_q[XLEN-2:0], ge};
        neg_q   = ~op_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        neg_r   = ~op_q[0] & a_q[XLEN-1];
        div_res = op_q[1] ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -q_fin : q_fin);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        accept  = (state_q == IDLE) & start & (AlUop[4:3] == 2'b01) & ~flush;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!AlUop[2]) begin
                        state_d = (MUL_CYCLES == 1) ? DONE : MUL;
                    end else begin
                        state_d = div_short ? DONE : DIV;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = DONE;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        stall  = accept | (busy & ~done);
        result = result_q;
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;

        // MUL starts its counter at 1 so the count equals cycles since accept.
        if (state_d == MUL || state_d == DIV) begin
            if (state_q == IDLE) begin
                cnt_d = (state_d == MUL) ? 5'd1 : 5'd0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end else begin
            cnt_d = '0;
        end

        if (accept) begin
            op_d  = AlUop[1:0];
            a_d   = operand_A;
            b_d   = operand_B;
            quo_d = a_mag;
            rem_d = '0;
            dvs_d = b_mag;
        end else if (state_q == DIV) begin
            quo_d = q_fin;
            rem_d = rem_nx;
        end

        if (state_d == DONE) begin
            case (state_q)
                IDLE:    result_d = AlUop[2] ? short_res : mul_res;
                MUL:     result_d = mul_res;
                DIV:     result_d = div_res;
                default: result_d = result_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

endmodule
